// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with request/ack data-memory port and registered MEM/WB slot
// Optional misaligned-access trap: define MEM_STAGE_ALIGN_CHECK_EN.
module mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_write_data,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic              mem_reg_write,
    input  logic              mem_vreg_write,
    input  logic              mem_mem_to_reg,
    input  logic              mem_mem_write,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_result,
    output logic [REG_W-1:0]  wb_rd,
    output logic              wb_reg_write,
    output logic              wb_vreg_write,
    output logic              err_misalign
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic                we_q, we_d, rw_q, rw_d, vw_q, vw_d;
    logic [REG_W-1:0]    rd_q, rd_d;
    logic                wb_valid_q, wb_valid_d, wb_rw_q, wb_rw_d, wb_vw_q, wb_vw_d;
    logic [DATA_W-1:0]   wb_result_q, wb_result_d;
    logic [REG_W-1:0]    wb_rd_q, wb_rd_d;
    logic                access, misalign, issue;

    assign access = mem_valid & (mem_mem_to_reg | mem_mem_write);

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    logic err_q, err_d;
    assign misalign     = access & (mem_alu_result[1:0] != 2'b00);
    assign err_misalign = err_q;
`else
    assign misalign     = 1'b0;
    assign err_misalign = 1'b0;
`endif

    assign issue = access & ~misalign;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        rd_d        = rd_q;
        rw_d        = rw_q;
        vw_d        = vw_q;
        wb_valid_d  = 1'b0;
        wb_rw_d     = 1'b0;
        wb_vw_d     = 1'b0;
        wb_result_d = wb_result_q;
        wb_rd_d     = wb_rd_q;
        stall       = 1'b0;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (issue) begin
                    // Load+store both set behaves as a store.
                    stall   = 1'b1;
                    state_d = BUSY;
                    addr_d  = mem_alu_result;
                    wdata_d = mem_write_data;
                    we_d    = mem_mem_write;
                    rd_d    = mem_rd;
                    rw_d    = mem_reg_write;
                    vw_d    = mem_vreg_write;
                end else if (misalign) begin
                    wb_valid_d  = 1'b1;
                    wb_result_d = mem_alu_result;
                    wb_rd_d     = mem_rd;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
                    err_d       = 1'b1;
`endif
                end else begin
                    wb_valid_d  = mem_valid;
                    wb_result_d = mem_alu_result;
                    wb_rd_d     = mem_rd;
                    wb_rw_d     = mem_valid & mem_reg_write;
                    wb_vw_d     = mem_valid & mem_vreg_write;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    // Releasing stall here lets upstream advance, so the held access is not re-issued.
                    state_d     = IDLE;
                    wb_valid_d  = 1'b1;
                    wb_result_d = we_q ? addr_q : dmem_rdata;
                    wb_rd_d     = rd_q;
                    wb_rw_d     = rw_q;
                    wb_vw_d     = vw_q;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            rd_q        <= '0;
            rw_q        <= 1'b0;
            vw_q        <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_result_q <= '0;
            wb_rd_q     <= '0;
            wb_rw_q     <= 1'b0;
            wb_vw_q     <= 1'b0;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            rd_q        <= rd_d;
            rw_q        <= rw_d;
            vw_q        <= vw_d;
            wb_valid_q  <= wb_valid_d;
            wb_result_q <= wb_result_d;
            wb_rd_q     <= wb_rd_d;
            wb_rw_q     <= wb_rw_d;
            wb_vw_q     <= wb_vw_d;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
            err_q       <= err_d;
`endif
        end
    end

    // Request port is driven purely from registered state.
    assign dmem_req      = (state_q == BUSY);
    assign dmem_we       = dmem_req & we_q;
    assign dmem_addr     = dmem_req ? addr_q : '0;
    assign dmem_wdata    = dmem_req ? wdata_q : '0;

    assign wb_valid      = wb_valid_q;
    assign wb_result     = wb_result_q;
    assign wb_rd         = wb_rd_q;
    assign wb_reg_write  = wb_rw_q;
    assign wb_vreg_write = wb_vw_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard testbench for mem_stage
module tb_mem_stage;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        rw;
        logic        vw;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_alu_result = '0;
    logic [31:0] mem_write_data = '0;
    logic [4:0]  mem_rd = '0;
    logic        mem_reg_write = 1'b0, mem_vreg_write = 1'b0;
    logic        mem_mem_to_reg = 1'b0, mem_mem_write = 1'b0;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid, wb_reg_write, wb_vreg_write, err_misalign;
    logic [31:0] wb_result;
    logic [4:0]  wb_rd;

    int  tests = 0;
    int  fails = 0;
    wb_t exp_q[$];

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
        .mem_write_data(mem_write_data), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_vreg_write(mem_vreg_write),
        .mem_mem_to_reg(mem_mem_to_reg), .mem_mem_write(mem_mem_write),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_result(wb_result), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .wb_vreg_write(wb_vreg_write),
        .err_misalign(err_misalign)
    );

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every WB slot the DUT presents must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_wb", {27'b0, wb_rd, wb_result}, 64'h0);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                check(wb_result === e.result, "wb_result", wb_result, e.result);
                check(wb_rd === e.rd, "wb_rd", wb_rd, e.rd);
                check({wb_reg_write, wb_vreg_write} === {e.rw, e.vw}, "wb_enables",
                      {wb_reg_write, wb_vreg_write}, {e.rw, e.vw});
            end
        end
    end

    task automatic idle_inputs();
        mem_valid = 0; mem_mem_to_reg = 0; mem_mem_write = 0;
        mem_reg_write = 0; mem_vreg_write = 0;
    endtask

    // Called at posedge+1; leaves at posedge+1.
    task automatic run_alu(input logic [31:0] alu, input logic [4:0] rd, input logic rw, vw);
        mem_valid = 1; mem_alu_result = alu; mem_rd = rd;
        mem_reg_write = rw; mem_vreg_write = vw; mem_mem_to_reg = 0; mem_mem_write = 0;
        exp_q.push_back('{result: alu, rd: rd, rw: rw, vw: vw});
        @(negedge clk);
        check(stall === 1'b0, "alu_stall", stall, 0);
        check(dmem_req === 1'b0, "alu_no_req", dmem_req, 0);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic run_access(input logic [31:0] alu, wd, rdat, input logic [4:0] rd,
                              input logic rw, vw, ld, st, input int nwait);
        int  win  = 0;
        int  reqc = 0;
        bit  done = 0;
        mem_valid = 1; mem_alu_result = alu; mem_write_data = wd; mem_rd = rd;
        mem_reg_write = rw; mem_vreg_write = vw; mem_mem_to_reg = ld; mem_mem_write = st;
        exp_q.push_back('{result: (st ? alu : rdat), rd: rd, rw: rw, vw: vw});
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (dmem_req) begin
                reqc++;
                check(dmem_addr === alu, "req_addr", dmem_addr, alu);
                check(dmem_we === st, "req_we", dmem_we, st);
                if (st) check(dmem_wdata === wd, "req_wdata", dmem_wdata, wd);
                if (reqc == nwait + 1) begin
                    dmem_ack = 1; dmem_rdata = rdat; done = 1;
                end
                #1;
                check(stall === !dmem_ack, "busy_stall", stall, !dmem_ack);
            end else begin
                check(stall === 1'b1, "issue_stall", stall, 1);
            end
            if (stall || dmem_req) win++;
            @(posedge clk); #1;
            dmem_ack = 0;
        end
        if (!done) check(1'b0, "ack_timeout", reqc, nwait + 1);
        idle_inputs();
        check(reqc == nwait + 1, "req_cycles", reqc, nwait + 1);
        check(win == nwait + 2, "occupancy_cycles", win, nwait + 2);
    endtask

    initial begin
        #12;
        check(wb_valid === 0 && wb_result === 0 && wb_rd === 0, "reset_wb", {wb_valid, wb_result}, 0);
        check(dmem_req === 0 && dmem_we === 0 && dmem_addr === 0 && dmem_wdata === 0,
              "reset_dmem", {dmem_req, dmem_addr}, 0);
        check(stall === 0 && err_misalign === 0, "reset_stall_err", {stall, err_misalign}, 0);
        @(posedge clk); #1; rst = 0;
        @(posedge clk); #1;

        run_alu(32'h0000_1234, 5'd3, 1, 0);
        run_alu(32'h0000_55AA, 5'd9, 0, 1);
        @(posedge clk); #1;   // bubble: nothing expected on WB
        run_access(32'h40, 32'h0, 32'hDEAD_BEEF, 5'd6, 1, 0, 1, 0, 0);
        run_access(32'h80, 32'hCAFE_F00D, 32'h0, 5'd0, 0, 0, 0, 1, 3);
        run_access(32'h100, 32'h0, 32'h0123_4567, 5'd12, 0, 1, 1, 0, 1);
        run_access(32'h200, 32'h1111_2222, 32'hFFFF_FFFF, 5'd2, 0, 0, 1, 1, 0);

        // Stray ack while idle must not produce a request or a WB slot.
        dmem_ack = 1; dmem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        check(dmem_req === 0 && stall === 0, "idle_ack_ignored", {dmem_req, stall}, 0);
        @(posedge clk); #1; dmem_ack = 0;
        @(posedge clk); #1;

        // Reset while BUSY.
        mem_valid = 1; mem_alu_result = 32'h300; mem_rd = 5'd4; mem_reg_write = 1; mem_mem_to_reg = 1;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check(dmem_req === 1, "busy_before_reset", dmem_req, 1);
        rst = 1; #1;
        check(dmem_req === 0 && stall === 0 && wb_valid === 0, "reset_in_busy",
              {dmem_req, stall, wb_valid}, 0);
        @(posedge clk); #1; rst = 0; dmem_ack = 1; dmem_rdata = 32'h7777_7777;
        @(negedge clk);
        check(dmem_req === 0 && stall === 0, "post_reset_ack", {dmem_req, stall}, 0);
        @(posedge clk); #1; dmem_ack = 0;
        @(negedge clk);
        check(wb_valid === 0, "post_reset_no_wb", wb_valid, 0);
        @(posedge clk); #1;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
        mem_valid = 1; mem_alu_result = 32'h42; mem_rd = 5'd7; mem_reg_write = 1; mem_mem_to_reg = 1;
        exp_q.push_back('{result: 32'h42, rd: 5'd7, rw: 1'b0, vw: 1'b0});
        @(negedge clk);
        check(stall === 0 && dmem_req === 0, "misalign_no_issue", {stall, dmem_req}, 0);
        @(posedge clk); #1;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check(err_misalign === 1 && dmem_req === 0, "misalign_sticky", {err_misalign, dmem_req}, 2'b10);
            @(posedge clk); #1;
        end
`else
        run_access(32'h42, 32'h0, 32'hA5A5_0042, 5'd7, 1, 0, 1, 0, 0);
        @(negedge clk);
        check(err_misalign === 0, "no_align_check", err_misalign, 0);
        @(posedge clk); #1;
`endif

        repeat (2) @(posedge clk);
        #1;
        check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
